maxpool_2x2_stream: RTL and testbench
=====================================

MAXPOOL_2X2_STREAM -- requirements
Module: maxpool_2x2_stream

Interface
REQ-001 SHALL have parameter N, default 16, meaning data bit width, two's-complement signed.
REQ-002 SHALL have parameter Q, default 12, meaning fractional bits; informational only, with no arithmetic effect.
REQ-003 SHALL have parameter W, default 28, meaning feature-map width in pixels; even, >=2.
REQ-004 SHALL have parameter H, default 28, meaning feature-map height in rows; even, >=2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data carries a pixel this cycle.
REQ-008 SHALL have port in_data, input, N bits: pixel in raster order (row-major, left to right), normally the ReLU stage output.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds one pooled result this cycle.
REQ-010 SHALL have port out_data, output, N bits: 2x2 window maximum.
REQ-011 SHALL have port frame_done, output, 1 bit: single-cycle pulse on the last pooled output of a frame.

Function
REQ-012 SHALL accept a pixel on every rising edge with in_valid=1; there is no backpressure; idle cycles (in_valid=0) SHALL leave all state unchanged.
REQ-013 SHALL keep column counter col (0..W-1) and row counter row (0..H-1); col SHALL increment per accepted pixel and wrap to 0 after W-1, incrementing row; row SHALL wrap to 0 after H-1.
REQ-014 SHALL latch the accepted pixel into hold register h when col is even.
REQ-015 SHALL compute pair maximum m = max(h, in_data) when col is odd.
REQ-016 SHALL use signed two's-complement comparison for all maxima; ties select either operand, since the two are bit-identical.
REQ-017 SHALL write m into line buffer entry col/2 on odd col of an even row; the line buffer has W/2 entries of N bits.
REQ-018 SHALL, on odd col of an odd row, register out_data = max(buffer[col/2], m) and assert out_valid for exactly one cycle, on the cycle following the accepting edge (latency 1).
REQ-019 SHALL emit exactly (W/2)*(H/2) results per frame, in raster order of the pooled map.
REQ-020 SHALL assert frame_done in the same cycle as out_valid for the pixel at row=H-1, col=W-1.
REQ-021 SHALL, while out_valid=0, hold out_data at its last value.
REQ-022 SHALL accept back-to-back frames with zero gap cycles; the next frame's first pixel may arrive on the cycle after the previous frame's last pixel.
REQ-023 SHALL require no arithmetic beyond comparison: output width equals N, with no saturation or rounding.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, clear col, row, h, out_data, out_valid and frame_done to 0.
REQ-025 SHALL discard any partial window or frame on reset mid-frame; the first pixel accepted after reset is row 0, col 0.
REQ-026 SHALL give reset priority over a simultaneous in_valid; that pixel is dropped.
REQ-027 SHALL NOT require line-buffer contents to be cleared by reset, because every entry is written before it is read.

Structure
REQ-028 SHALL take the N/Q defaults and a signed-max function from the shared CNN package, alongside the ReLU stage's constants.
REQ-029 SHALL instantiate one sub-module, pool_line_buf: a W/2 x N storage array with one write port and one asynchronous read port, indexed by col/2.
REQ-030 SHALL contain the counters, hold register, comparators and output register in maxpool_2x2_stream itself.

Verification (W=4, H=4, N=16)
REQ-031 SHALL cover reset: hold reset=1 for 2 cycles -> out_valid=0, frame_done=0, out_data=0x0000.
REQ-032 SHALL cover ramp: 16 consecutive pixels 1..16 -> out_data 6, 8, 14, 16, each 1 cycle after pixels 6, 8, 14, 16; frame_done with 16.
REQ-033 SHALL cover signed compare: top-left window pixels {0xFFFB, 0x0001 / 0x8000, 0x0000}, rest 0xFFFF -> first output 0x0001, remaining outputs 0xFFFF.
REQ-034 SHALL cover gaps: ramp frame with 0-3 random idle cycles between pixels -> same four values; each out_valid 1 cycle after its final pixel.
REQ-035 SHALL cover reset mid-frame: 6 ramp pixels, reset 1 cycle, then full ramp frame -> exactly 6, 8, 14, 16, and no output from the aborted frame.
REQ-036 SHALL cover back-to-back frames: ramp then ramp+100 with no gap -> 6, 8, 14, 16, 106, 108, 114, 116; two frame_done pulses.

Source files
------------

// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared CNN constants (data format, ReLU stage) and the signed maximum helper.
// smax works on a wide signed type so callers of any width <= 64 bits can sign-extend into it.
package maxpool_2x2_stream_pkg;

  localparam int CNN_N  = 16;
  localparam int CNN_Q  = 12;
  localparam int RELU_N = CNN_N;
  localparam int RELU_Q = CNN_Q;

  localparam int SMAX_W = 64;
  typedef logic signed [SMAX_W-1:0] smax_t;

  function automatic smax_t smax(input smax_t a, input smax_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_line_buf.sv
// One-row store of horizontal pair maxima: one write port, asynchronous read.
module pool_line_buf #(
  parameter int DEPTH = 14,
  parameter int N     = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [N-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [N-1:0]  rd_data_o
);

  logic [N-1:0] mem_q [DEPTH];

  // No reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2/stride-2 max pool over a raster-order feature map, one result per odd-row odd-column pixel.
// Even rows leave pair maxima in the line buffer; odd rows combine them with their own pair maxima.
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int N = CNN_N,
  parameter int Q = CNN_Q,
  parameter int W = 28,
  parameter int H = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         frame_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int AW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [N-1:0]  h_q, h_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic          wr_en;
  logic [AW-1:0] buf_addr;
  logic [N-1:0]  buf_rd;
  logic [N-1:0]  pair_max;
  logic [N-1:0]  win_max;

  assign buf_addr = AW'(col_q >> 1);

  pool_line_buf #(
    .DEPTH(W / 2),
    .N    (N),
    .AW   (AW)
  ) u_line_buf (
    .clk      (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(buf_addr),
    .wr_data_i(pair_max),
    .rd_addr_i(buf_addr),
    .rd_data_o(buf_rd)
  );

  always_comb begin
    pair_max = N'(smax(smax_t'(signed'(h_q)), smax_t'(signed'(in_data))));
    win_max  = N'(smax(smax_t'(signed'(buf_rd)), smax_t'(signed'(pair_max))));
    wr_en    = in_valid && !reset && col_q[0] && !row_q[0];

    col_d        = col_q;
    row_d        = row_q;
    h_d          = h_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) h_d = in_data;
      if (col_q[0] && row_q[0]) begin
        out_data_d   = win_max;
        out_valid_d  = 1'b1;
        frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_q          <= h_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream on a 4x4 map: table of back-to-back frames plus gap and reset sequences.
module tb_maxpool_2x2_stream;

  localparam int N = 16;
  localparam int W = 4;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         frame_done;

  maxpool_2x2_stream #(.N(N), .Q(12), .W(W), .H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        ev;
    logic [15:0] eo;
    logic        ed;
  } vec_t;

  vec_t        vecs[48];
  int          nv = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] held = 16'h0000;
  logic [15:0] pix[16];
  logic [15:0] outs[4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Window results appear after raster pixels 6, 8, 14, 16 (indices 5, 7, 13, 15).
  task automatic add_frame();
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.din = pix[i];
      v.ev  = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (v.ev) begin
        held = outs[k];
        k++;
      end
      v.eo = held;
      v.ed = (i == 15);
      vecs[nv] = v;
      nv++;
    end
  endtask

  initial begin
    int          idle;
    int          nout;
    logic [15:0] g_held;
    logic [15:0] g_outs[4];
    int          ko;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 16'(out_valid), 16'h0);
    chk("reset_done", 16'(frame_done), 16'h0);
    chk("reset_data", out_data, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
    outs[0] = 16'd6; outs[1] = 16'd8; outs[2] = 16'd14; outs[3] = 16'd16;
    add_frame();

    for (int i = 0; i < 16; i++) pix[i] = 16'hFFFF;
    pix[0] = 16'hFFFB; pix[1] = 16'h0001; pix[4] = 16'h8000; pix[5] = 16'h0000;
    outs[0] = 16'h0001; outs[1] = 16'hFFFF; outs[2] = 16'hFFFF; outs[3] = 16'hFFFF;
    add_frame();

    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 101);
    outs[0] = 16'd106; outs[1] = 16'd108; outs[2] = 16'd114; outs[3] = 16'd116;
    add_frame();

    for (int i = 0; i < nv; i++) begin
      step(1'b1, vecs[i].din);
      chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].eo);
      chk($sformatf("vec%0d_done", i), 16'(frame_done), 16'(vecs[i].ed));
    end

    // Ramp frame with random idle cycles between pixels.
    g_outs[0] = 16'd6; g_outs[1] = 16'd8; g_outs[2] = 16'd14; g_outs[3] = 16'd16;
    g_held = 16'd116;
    ko = 0;
    for (int k = 0; k < 16; k++) begin
      idle = int'($urandom_range(0, 3));
      for (int j = 0; j < idle; j++) begin
        step(1'b0, 16'hDEAD);
        chk($sformatf("gap%0d_idle_valid", k), 16'(out_valid), 16'h0);
        chk($sformatf("gap%0d_idle_data", k), out_data, g_held);
      end
      step(1'b1, 16'(k + 1));
      if (k == 5 || k == 7 || k == 13 || k == 15) begin
        g_held = g_outs[ko];
        ko++;
        chk($sformatf("gap%0d_valid", k), 16'(out_valid), 16'h1);
      end else begin
        chk($sformatf("gap%0d_valid", k), 16'(out_valid), 16'h0);
      end
      chk($sformatf("gap%0d_data", k), out_data, g_held);
      chk($sformatf("gap%0d_done", k), 16'(frame_done), 16'(k == 15));
    end
    step(1'b0, 16'h0);
    chk("gap_tail_valid", 16'(out_valid), 16'h0);
    chk("gap_tail_done", 16'(frame_done), 16'h0);

    // Abort a frame: five pixels, then the sixth arrives together with reset and is dropped.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'(k + 1));
      chk($sformatf("abort%0d_valid", k), 16'(out_valid), 16'h0);
    end
    reset = 1'b1;
    step(1'b1, 16'd6);
    reset = 1'b0;
    chk("abort_rst_valid", 16'(out_valid), 16'h0);
    chk("abort_rst_data", out_data, 16'h0000);
    chk("abort_rst_done", 16'(frame_done), 16'h0);

    nout = 0;
    g_held = 16'h0000;
    ko = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 16'(k + 1));
      if (out_valid) nout++;
      if (k == 5 || k == 7 || k == 13 || k == 15) begin
        g_held = g_outs[ko];
        ko++;
      end
      chk($sformatf("post%0d_data", k), out_data, g_held);
      chk($sformatf("post%0d_done", k), 16'(frame_done), 16'(k == 15));
    end
    step(1'b0, 16'h0);
    chk("post_out_count", 16'(nout), 16'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
